// File: rtl/divide_pkg.sv
// rtl/divide_pkg.sv - shared types, constants and sign helpers for the divide unit
package divide_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Helpers work at the widest legal width; callers truncate to WIDTH,
    // which keeps two's-complement negation exact modulo 2**WIDTH.
    typedef logic [MAX_WIDTH-1:0] wide_t;

    function automatic wide_t negate(input wide_t value);
        return ~value + wide_t'(1);
    endfunction

    function automatic wide_t magnitude(input wide_t value, input logic is_neg);
        return is_neg ? negate(value) : value;
    endfunction

    function automatic wide_t apply_sign(input wide_t value, input logic make_neg);
        return make_neg ? negate(value) : value;
    endfunction

endpackage

// File: rtl/divide_step.sv
// rtl/divide_step.sv - one restoring division iteration (shift, subtract, select)
module divide_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    // The running remainder stays below the divisor, so the top bit of the
    // WIDTH+1-bit difference is set exactly when the subtraction borrows.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign borrow  = diff[WIDTH];

    assign rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/divide_unit.sv
// rtl/divide_unit.sv - iterative restoring divider with valid/ready handshake
module divide_unit
    import divide_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] rest,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic             alive;
    logic             zero_pend;
    logic             accept;
    logic             last_step;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic             dbz_out;
    logic             neg_q;
    logic             neg_r;
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic             divisor_zero;

    assign op_signed    = SIGNED_EN && signed_op;
    assign sign_a       = op_signed & dividend[WIDTH-1];
    assign sign_b       = op_signed & divisor[WIDTH-1];
    assign mag_a        = WIDTH'(magnitude(wide_t'(dividend), sign_a));
    assign mag_b        = WIDTH'(magnitude(wide_t'(divisor), sign_b));
    assign divisor_zero = (divisor == '0);

    divide_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .quo_in (quo_q),
        .dvs    (dvs_q),
        .rem_out(step_rem),
        .quo_out(step_quo)
    );

    // alive holds in_ready low while reset is asserted and releases it one
    // edge after reset deasserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            alive <= 1'b0;
        end else begin
            state <= next_state;
            alive <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = alive & ~zero_pend;
                if (zero_pend) begin
                    next_state = DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    last_step  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        accept = in_valid & in_ready;
        // A zero divisor spends one cycle in IDLE with zero_pend set, then DONE.
        if (accept) begin
            next_state = divisor_zero ? IDLE : RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_pend <= 1'b0;
            q_out     <= '0;
            r_out     <= '0;
            dbz_out   <= 1'b0;
        end else begin
            zero_pend <= 1'b0;
            if (accept) begin
                if (divisor_zero) begin
                    q_out     <= '1;
                    r_out     <= dividend;
                    dbz_out   <= 1'b1;
                    zero_pend <= 1'b1;
                end else begin
                    rem_q   <= '0;
                    quo_q   <= mag_a;
                    dvs_q   <= mag_b;
                    neg_q   <= sign_a ^ sign_b;
                    neg_r   <= sign_a;
                    cnt     <= CW'(WIDTH - 1);
                    dbz_out <= 1'b0;
                end
            end else if (state == RUN) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
                // Sign fixup happens once, as the last step retires.
                if (last_step) begin
                    q_out <= WIDTH'(apply_sign(wide_t'(step_quo), neg_q));
                    r_out <= WIDTH'(apply_sign(wide_t'(step_rem), neg_r));
                end
            end
        end
    end

    assign quotient    = q_out;
    assign rest        = r_out;
    assign div_by_zero = dbz_out;

endmodule

// File: tb/tb_divide_unit.sv
// tb/tb_divide_unit.sv - directed self-checking bench for divide_unit
module tb_divide_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        signed_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] rest;
    logic        div_by_zero;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    divide_unit #(
        .WIDTH    (32),
        .SIGNED_EN(1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .signed_op  (signed_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .rest       (rest),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Latency counts edges inclusively: the accept edge is edge 1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output int lat);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        q  = quotient;
        r  = rest;
        dz = div_by_zero;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        logic [31:0] q_hold;
        logic [31:0] r_hold;
        bit          stable;

        vecs[0] = '{"u_100_7",      32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b0, 33};
        vecs[1] = '{"s_m7_2",       32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[2] = '{"s_7_m2",       32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
        vecs[3] = '{"div0_1234",    32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1, 2};
        vecs[4] = '{"s_min_m1",     32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0, 33};
        vecs[5] = '{"u_min_m1",     32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000, 1'b0, 33};
        vecs[6] = '{"s_div0_m7",    32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2};
        vecs[7] = '{"u_max_1",      32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
        vecs[8] = '{"u_5_10",       32'd5,          32'd10,         1'b0, 32'd0,        32'd5,        1'b0, 33};
        vecs[9] = '{"s_m100_m7",    32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 33};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;

        #2;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_quotient", quotient, 32'd0);
        check_eq("rst_rest", rest, 32'd0);
        check_eq("rst_div_by_zero", div_by_zero, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_in_ready_held", in_ready, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("in_ready_before_edge", in_ready, 1'b0);
        @(posedge clock);
        #1;
        check_eq("in_ready_after_edge", in_ready, 1'b1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, lat);
            check_eq({vecs[i].name, "_q"}, q, vecs[i].q);
            check_eq({vecs[i].name, "_r"}, r, vecs[i].r);
            check_eq({vecs[i].name, "_dz"}, dz, vecs[i].dz);
            check_eq({vecs[i].name, "_lat"}, lat, vecs[i].lat);
        end

        // Result held under back-pressure, then back-to-back accept.
        @(negedge clock);
        dividend  = 32'd100;
        divisor   = 32'd7;
        signed_op = 1'b0;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check_eq("hold_q", quotient, 32'd14);
        check_eq("hold_in_ready_low", in_ready, 1'b0);
        q_hold = quotient;
        r_hold = rest;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (!out_valid || quotient !== q_hold || rest !== r_hold || div_by_zero !== 1'b0) begin
                stable = 1'b0;
            end
        end
        check_eq("hold_stable", stable, 1'b1);
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        #1;
        check_eq("b2b_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        dividend  = 32'hDEAD;
        divisor   = 32'd3;
        check_eq("b2b_busy", busy, 1'b1);
        check_eq("b2b_out_valid", out_valid, 1'b0);
        check_eq("run_in_ready", in_ready, 1'b0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq("b2b_q", quotient, 32'd100);
        check_eq("b2b_r", rest, 32'd0);
        check_eq("b2b_lat", lat, 33);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN abandons the operation.
        @(negedge clock);
        dividend  = 32'd100;
        divisor   = 32'd7;
        signed_op = 1'b0;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        check_eq("mid_busy", busy, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_quotient", quotient, 32'd0);
        check_eq("mid_rst_rest", rest, 32'd0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clock);
        #1;
        check_eq("mid_rst_out_valid_edge", out_valid, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat);
        check_eq("post_rst_q", q, 32'd14);
        check_eq("post_rst_r", r, 32'd2);
        check_eq("post_rst_lat", lat, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
